// File: rtl/chess_turn_scheduler_pkg.sv
// Encodings shared by the turn scheduler and the layout matrix so both sides
// agree on player colour and game-state values.
package chess_turn_scheduler_pkg;

  localparam logic WHITE_PLAYER = 1'b1;
  localparam logic BLACK_PLAYER = 1'b0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic ON    = 1'b1;
  localparam logic OFF   = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSE  = 3'd2,
    ST_SWITCH = 3'd3,
    ST_OVER   = 3'd4
  } game_state_e;

endpackage

// File: rtl/chess_player_clock.sv
// One player's countdown clock: reload to GAME_TIME, tick down, add the
// per-move bonus with saturation at TIME_MAX. Load beats increment beats decrement.
module chess_player_clock #(
  parameter int TIME_W    = 14,
  parameter int GAME_TIME = 3000,
  parameter int INCREMENT = 50,
  parameter int TIME_MAX  = 16383
) (
  input  logic              OutClock,
  input  logic              resetApp,
  input  logic              load_i,
  input  logic              dec_i,
  input  logic              inc_i,
  output logic [TIME_W-1:0] time_o,
  output logic              zero_o
);

  logic [TIME_W-1:0] time_q, time_d;
  logic [TIME_W:0]   sum;

  // One extra bit so the bonus addition cannot wrap before the ceiling test.
  assign sum = {1'b0, time_q} + (TIME_W+1)'(INCREMENT);

  always_comb begin
    time_d = time_q;
    if (load_i) begin
      time_d = TIME_W'(GAME_TIME);
    end else if (inc_i) begin
      time_d = (sum > (TIME_W+1)'(TIME_MAX)) ? TIME_W'(TIME_MAX) : sum[TIME_W-1:0];
    end else if (dec_i && !zero_o) begin
      time_d = time_q - TIME_W'(1);
    end
  end

  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) begin
      time_q <= TIME_W'(GAME_TIME);
    end else begin
      time_q <= time_d;
    end
  end

  assign time_o = time_q;
  assign zero_o = (time_q == '0);

endmodule

// File: rtl/chess_turn_scheduler.sv
// Timed-game sequencer: side to move, two player clocks, move counter and game
// state; grants MoveEnable to the layout datapath only while running.
module chess_turn_scheduler
  import chess_turn_scheduler_pkg::*;
#(
  parameter int TIME_W    = 14,
  parameter int GAME_TIME = 3000,
  parameter int INCREMENT = 50,
  parameter int TIME_MAX  = 16383,
  parameter int COUNT_W   = 8
) (
  input  logic               OutClock,
  input  logic               resetApp,
  input  logic               StartGame,
  input  logic               PauseSwitch,
  input  logic               MoveDone,
  input  logic               MovePlayer,
  output logic               Player,
  output logic               MoveEnable,
  output logic [2:0]         GameState,
  output logic [TIME_W-1:0]  WhiteTime,
  output logic [TIME_W-1:0]  BlackTime,
  output logic [COUNT_W-1:0] MoveCount,
  output logic               Timeout,
  output logic               Winner
);

  game_state_e          state_q;
  logic                 player_q;
  logic [COUNT_W-1:0]   count_q;
  logic                 timeout_q;
  logic                 winner_q;

  logic                 valid_move, run_tick, expire, reload;
  logic                 white_zero, black_zero, active_zero;
  logic [TIME_W-1:0]    active_time;
  logic                 white_dec, black_dec, white_inc, black_inc;

  assign active_time = (player_q == WHITE_PLAYER) ? WhiteTime  : BlackTime;
  assign active_zero = (player_q == WHITE_PLAYER) ? white_zero : black_zero;

  // A commit outranks a pause request, which outranks the clock tick.
  assign valid_move = (state_q == ST_RUN) && MoveDone && (MovePlayer == player_q);
  assign run_tick   = (state_q == ST_RUN) && !valid_move && !PauseSwitch && !active_zero;
  assign expire     = run_tick && (active_time == TIME_W'(1));
  assign reload     = (state_q == ST_OVER) && StartGame;

  assign white_dec = run_tick && (player_q == WHITE_PLAYER);
  assign black_dec = run_tick && (player_q == BLACK_PLAYER);
  // Player has not toggled yet while in SWITCH, so player_q is still the mover.
  assign white_inc = (state_q == ST_SWITCH) && (player_q == WHITE_PLAYER);
  assign black_inc = (state_q == ST_SWITCH) && (player_q == BLACK_PLAYER);

  chess_player_clock #(
    .TIME_W(TIME_W), .GAME_TIME(GAME_TIME), .INCREMENT(INCREMENT), .TIME_MAX(TIME_MAX)
  ) u_white_clock (
    .OutClock(OutClock), .resetApp(resetApp),
    .load_i(reload), .dec_i(white_dec), .inc_i(white_inc),
    .time_o(WhiteTime), .zero_o(white_zero)
  );

  chess_player_clock #(
    .TIME_W(TIME_W), .GAME_TIME(GAME_TIME), .INCREMENT(INCREMENT), .TIME_MAX(TIME_MAX)
  ) u_black_clock (
    .OutClock(OutClock), .resetApp(resetApp),
    .load_i(reload), .dec_i(black_dec), .inc_i(black_inc),
    .time_o(BlackTime), .zero_o(black_zero)
  );

  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) begin
      state_q   <= ST_IDLE;
      player_q  <= WHITE_PLAYER;
      count_q   <= '0;
      timeout_q <= FALSE;
      winner_q  <= BLACK_PLAYER;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (StartGame) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (valid_move) begin
            state_q <= ST_SWITCH;
          end else if (PauseSwitch) begin
            state_q <= ST_PAUSE;
          end else if (expire) begin
            state_q   <= ST_OVER;
            timeout_q <= TRUE;
            winner_q  <= ~player_q;
          end
        end
        ST_SWITCH: begin
          player_q <= ~player_q;
          count_q  <= count_q + COUNT_W'(1);
          state_q  <= PauseSwitch ? ST_PAUSE : ST_RUN;
        end
        ST_PAUSE: begin
          if (!PauseSwitch) state_q <= ST_RUN;
        end
        ST_OVER: begin
          if (StartGame) begin
            state_q   <= ST_IDLE;
            player_q  <= WHITE_PLAYER;
            count_q   <= '0;
            timeout_q <= FALSE;
            winner_q  <= BLACK_PLAYER;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Player     = player_q;
  assign GameState  = state_q;
  assign MoveCount  = count_q;
  assign Timeout    = timeout_q;
  assign Winner     = winner_q;
  assign MoveEnable = (state_q == ST_RUN);

endmodule

// File: tb/tb_chess_turn_scheduler.sv
// Directed bench for chess_turn_scheduler with a rule-level reference model
// checked every falling edge, plus hand-computed literal checkpoints.
module tb_chess_turn_scheduler;

  localparam int TW   = 14;
  localparam int CW   = 8;
  localparam int GT   = 20;
  localparam int INC  = 5;
  localparam int TMAX = 30;

  logic          OutClock = 1'b0;
  logic          resetApp = 1'b1;
  logic          StartGame = 1'b0;
  logic          PauseSwitch = 1'b0;
  logic          MoveDone = 1'b0;
  logic          MovePlayer = 1'b0;
  logic          Player, MoveEnable, Timeout, Winner;
  logic [2:0]    GameState;
  logic [TW-1:0] WhiteTime, BlackTime;
  logic [CW-1:0] MoveCount;

  int n_cmp = 0;
  int n_bad = 0;

  chess_turn_scheduler #(
    .TIME_W(TW), .GAME_TIME(GT), .INCREMENT(INC), .TIME_MAX(TMAX), .COUNT_W(CW)
  ) dut (
    .OutClock(OutClock), .resetApp(resetApp), .StartGame(StartGame),
    .PauseSwitch(PauseSwitch), .MoveDone(MoveDone), .MovePlayer(MovePlayer),
    .Player(Player), .MoveEnable(MoveEnable), .GameState(GameState),
    .WhiteTime(WhiteTime), .BlackTime(BlackTime), .MoveCount(MoveCount),
    .Timeout(Timeout), .Winner(Winner)
  );

  always #5 OutClock = ~OutClock;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: game rules written as plain integer bookkeeping.
  int m_st, m_pl, m_wt, m_bt, m_cnt, m_to, m_win;

  function automatic int bonus(input int t);
    return (t + INC > TMAX) ? TMAX : t + INC;
  endfunction

  always @(posedge OutClock or posedge resetApp) begin
    if (resetApp) begin
      m_st <= 0; m_pl <= 1; m_wt <= GT; m_bt <= GT; m_cnt <= 0; m_to <= 0; m_win <= 0;
    end else begin
      case (m_st)
        0: if (StartGame) m_st <= 1;
        1: begin
          if (MoveDone && (int'(MovePlayer) == m_pl)) m_st <= 3;
          else if (PauseSwitch) m_st <= 2;
          else if (m_pl == 1) begin
            m_wt <= m_wt - 1;
            if (m_wt == 1) begin m_st <= 4; m_to <= 1; m_win <= 0; end
          end else begin
            m_bt <= m_bt - 1;
            if (m_bt == 1) begin m_st <= 4; m_to <= 1; m_win <= 1; end
          end
        end
        3: begin
          if (m_pl == 1) m_wt <= bonus(m_wt);
          else           m_bt <= bonus(m_bt);
          m_pl  <= 1 - m_pl;
          m_cnt <= (m_cnt + 1) % 256;
          m_st  <= PauseSwitch ? 2 : 1;
        end
        2: if (!PauseSwitch) m_st <= 1;
        4: if (StartGame) begin
          m_st <= 0; m_pl <= 1; m_wt <= GT; m_bt <= GT; m_cnt <= 0; m_to <= 0; m_win <= 0;
        end
        default: m_st <= 0;
      endcase
    end
  end

  always @(negedge OutClock) begin
    if (!resetApp) begin
      chk("GameState", int'(GameState), m_st);
      chk("Player", int'(Player), m_pl);
      chk("WhiteTime", int'(WhiteTime), m_wt);
      chk("BlackTime", int'(BlackTime), m_bt);
      chk("MoveCount", int'(MoveCount), m_cnt);
      chk("Timeout", int'(Timeout), m_to);
      chk("MoveEnable", int'(MoveEnable), (m_st == 1) ? 1 : 0);
      if (m_st == 4) chk("Winner", int'(Winner), m_win);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge OutClock);
  endtask

  task automatic move(input logic colour);
    MoveDone = 1'b1; MovePlayer = colour;
    tick(1);
    MoveDone = 1'b0;
    tick(1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, int'(GameState), 0);
    chk({tag, "_player"}, int'(Player), 1);
    chk({tag, "_wt"}, int'(WhiteTime), GT);
    chk({tag, "_bt"}, int'(BlackTime), GT);
    chk({tag, "_cnt"}, int'(MoveCount), 0);
    chk({tag, "_to"}, int'(Timeout), 0);
    chk({tag, "_win"}, int'(Winner), 0);
    chk({tag, "_me"}, int'(MoveEnable), 0);
  endtask

  initial begin
    tick(2);
    chk_reset_vals("rst");
    resetApp = 1'b0;

    // White flag falls with no moves made.
    StartGame = 1'b1; tick(1); StartGame = 1'b0;
    tick(20);
    chk("flag_wt", int'(WhiteTime), 0);
    chk("flag_state", int'(GameState), 4);
    chk("flag_to", int'(Timeout), 1);
    chk("flag_win", int'(Winner), 0);
    chk("flag_bt", int'(BlackTime), GT);
    chk("flag_me", int'(MoveEnable), 0);
    tick(3);
    StartGame = 1'b1; tick(1); StartGame = 1'b0;
    chk("reload_state", int'(GameState), 0);
    chk("reload_wt", int'(WhiteTime), GT);
    chk("reload_bt", int'(BlackTime), GT);
    chk("reload_to", int'(Timeout), 0);
    tick(1);

    // White commits after four ticks, then only black's clock runs.
    StartGame = 1'b1; tick(1); StartGame = 1'b0;
    tick(4);
    chk("w4_wt", int'(WhiteTime), 16);
    MoveDone = 1'b1; MovePlayer = 1'b1; tick(1); MoveDone = 1'b0;
    chk("sw_state", int'(GameState), 3);
    chk("sw_wt", int'(WhiteTime), 16);
    tick(1);
    chk("post_wt", int'(WhiteTime), 21);
    chk("post_pl", int'(Player), 0);
    chk("post_cnt", int'(MoveCount), 1);
    tick(3);
    chk("b3_bt", int'(BlackTime), 17);
    chk("b3_wt", int'(WhiteTime), 21);

    // Wrong-colour commit is ignored.
    MoveDone = 1'b1; MovePlayer = 1'b1; tick(1); MoveDone = 1'b0;
    chk("inv_bt", int'(BlackTime), 16);
    chk("inv_cnt", int'(MoveCount), 1);

    // Commits during pause are ignored and clocks freeze.
    PauseSwitch = 1'b1; tick(1);
    MoveDone = 1'b1; MovePlayer = 1'b0; tick(2); MoveDone = 1'b0;
    chk("pause_state", int'(GameState), 2);
    chk("pause_bt", int'(BlackTime), 16);
    chk("pause_cnt", int'(MoveCount), 1);
    PauseSwitch = 1'b0; tick(2);
    chk("resume_bt", int'(BlackTime), 15);
    move(1'b0);
    chk("bmove_bt", int'(BlackTime), 20);
    chk("bmove_pl", int'(Player), 1);

    // Commit and pause together on the white clock's last tick.
    tick(20);
    chk("last_wt", int'(WhiteTime), 1);
    MoveDone = 1'b1; MovePlayer = 1'b1; PauseSwitch = 1'b1; tick(1); MoveDone = 1'b0;
    chk("sim_state", int'(GameState), 3);
    chk("sim_to", int'(Timeout), 0);
    tick(1);
    chk("sim_wt", int'(WhiteTime), 6);
    chk("sim_state2", int'(GameState), 2);
    chk("sim_cnt", int'(MoveCount), 3);
    tick(3);
    chk("sim_frozen_bt", int'(BlackTime), 20);
    PauseSwitch = 1'b0; tick(1);
    chk("sim_run", int'(GameState), 1);
    chk("sim_pl", int'(Player), 0);

    // Saturation: bring white to 28, then commit.
    resetApp = 1'b1; tick(1); resetApp = 1'b0;
    StartGame = 1'b1; tick(1); StartGame = 1'b0;
    move(1'b1);
    move(1'b0);
    tick(2);
    move(1'b1);
    move(1'b0);
    chk("pre_sat_wt", int'(WhiteTime), 28);
    move(1'b1);
    chk("sat_wt", int'(WhiteTime), TMAX);
    chk("sat_cnt", int'(MoveCount), 5);

    // Asynchronous reset mid-run with black at 7.
    tick(23);
    chk("pre_rst_bt", int'(BlackTime), 7);
    #3 resetApp = 1'b1;
    #1 chk_reset_vals("arst");
    tick(2);
    resetApp = 1'b0;

    // Black flag falls; StartGame in RUN is ignored.
    StartGame = 1'b1; tick(1); StartGame = 1'b0;
    move(1'b1);
    StartGame = 1'b1; tick(3); StartGame = 1'b0;
    tick(17);
    chk("bflag_state", int'(GameState), 4);
    chk("bflag_win", int'(Winner), 1);
    chk("bflag_wt", int'(WhiteTime), 25);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
